// File: rtl/fx_pkg.sv
// Shared definitions for the front-panel effect controller.
//   state_t      : controller state codes (also driven out on o_state)
//   loop_mode_t  : what the loop address generator is doing this cycle
//   EFF_*        : effect slot indices into the packed parameter bank
//   param_step   : one increment/decrement step of a parameter, wrap or clamp
//   state_leds   : one-hot green LED pattern for a state
package fx_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_PLAY  = 3'd1,
        S_SET   = 3'd2,
        S_RECD  = 3'd3,
        S_PLAYL = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        LM_IDLE = 2'd0,
        LM_REC  = 2'd1,
        LM_PLAY = 2'd2
    } loop_mode_t;

    localparam int EFF_GATE = 0;
    localparam int EFF_COMP = 1;
    localparam int EFF_DIST = 2;
    localparam int EFF_EQ   = 3;
    localparam int EFF_CHOR = 4;
    localparam int EFF_FLNG = 5;
    localparam int EFF_TREM = 6;
    localparam int EFF_DEL  = 7;

    // Parameters of any width up to PSTEP_W bits go through param_step;
    // max_val is the all-ones value of the caller's parameter width.
    localparam int PSTEP_W = 16;

    function automatic logic [PSTEP_W-1:0] param_step(
        input logic [PSTEP_W-1:0] val,
        input logic               inc,
        input logic               dec,
        input logic               sat,
        input logic [PSTEP_W-1:0] max_val
    );
        logic [PSTEP_W-1:0] r;
        r = val;
        if (inc && !dec) begin
            if (val == max_val) r = sat ? max_val : '0;
            else                r = val + 1'b1;
        end else if (dec && !inc) begin
            if (val == '0) r = sat ? '0 : max_val;
            else           r = val - 1'b1;
        end
        return r;
    endfunction

    function automatic logic [8:0] state_leds(input state_t s);
        logic [8:0] l;
        case (s)
            S_PLAY:  l = 9'h001;
            S_SET:   l = 9'h002;
            S_RECD:  l = 9'h004;
            S_PLAYL: l = 9'h008;
            default: l = 9'h100;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/fx_ctrl_sequencer_loop_addr_gen.sv
// Loop memory address generator: owns the sample counter and recorded length,
// and issues one-cycle write (record) / read (playback) strobes per tick.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   mode         : LM_REC records, LM_PLAY plays back, LM_IDLE holds
//   start        : clear the counter ahead of a new recording (idle mode only)
//   stop         : loop key edge; in record mode latches the length
//   tick         : one-cycle pulse per audio sample
//   addr, len    : registered memory address / recorded length
//   wr, rd       : registered write / read strobes
//   full         : combinational, this tick writes the last address
//   empty        : combinational, counter is at zero
module loop_addr_gen
    import fx_pkg::*;
#(
    parameter int LW = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  loop_mode_t      mode,
    input  logic            start,
    input  logic            stop,
    input  logic            tick,
    output logic [LW-1:0]   addr,
    output logic [LW-1:0]   len,
    output logic            wr,
    output logic            rd,
    output logic            full,
    output logic            empty
);

    localparam logic [LW-1:0] ADDR_MAX = '1;

    logic [LW-1:0] cnt;

    assign full  = (mode == LM_REC) && tick && (cnt == ADDR_MAX);
    assign empty = (cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt  <= '0;
            addr <= '0;
            len  <= '0;
            wr   <= 1'b0;
            rd   <= 1'b0;
        end else begin
            wr <= 1'b0;
            rd <= 1'b0;
            case (mode)
                LM_REC: begin
                    if (tick) begin
                        wr   <= 1'b1;
                        addr <= cnt;
                    end
                    // A tick coinciding with stop is written first and counted.
                    if (full) begin
                        len <= ADDR_MAX;
                        cnt <= '0;
                    end else if (stop) begin
                        len <= tick ? cnt + 1'b1 : cnt;
                        cnt <= '0;
                    end else if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LM_PLAY: begin
                    if (tick) begin
                        rd   <= 1'b1;
                        addr <= cnt;
                        cnt  <= (cnt >= len - 1'b1) ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                    if (start) cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fx_ctrl_sequencer.sv
// Front-panel controller for the guitar effect chain: key edge detection,
// per-effect parameter bank with inc/dec (wrap or saturate), and a loop
// record/playback sequencer driving loop SRAM strobes. All outputs registered.
// Ports:
//   i_clk, i_rst          : clock, async active-high reset
//   i_init_done           : codec configuration finished
//   i_key_inc/dec/loop/mode : debounced key levels
//   i_sel                 : selected effect index
//   i_fx_en               : effect enable switches
//   i_sample_tick         : one-cycle pulse per audio sample
//   o_state, o_ledg       : state code and one-hot state LEDs
//   o_params, o_cur_val   : parameter bank, selected parameter in SET
//   o_ledr                : selected effect in SET, else enable switches
//   o_loop_wr/rd/addr/len : loop memory interface
//
// state   | meaning
// S_INIT  | waiting for codec configuration
// S_PLAY  | normal effect playback
// S_SET   | editing the parameter of the selected effect
// S_RECD  | recording samples into loop memory
// S_PLAYL | playing the recorded loop back
module fx_ctrl_sequencer
    import fx_pkg::*;
#(
    parameter int                 N_FX      = 8,
    parameter int                 PW        = 3,
    parameter int                 LW        = 20,
    parameter bit                 SAT       = 1'b0,
    parameter logic [N_FX*PW-1:0] P_DEFAULT = '0,
    localparam int                SW        = $clog2(N_FX)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_init_done,
    input  logic                 i_key_inc,
    input  logic                 i_key_dec,
    input  logic                 i_key_loop,
    input  logic                 i_key_mode,
    input  logic [SW-1:0]        i_sel,
    input  logic [N_FX-1:0]      i_fx_en,
    input  logic                 i_sample_tick,
    output logic [2:0]           o_state,
    output logic [N_FX*PW-1:0]   o_params,
    output logic [PW-1:0]        o_cur_val,
    output logic [8:0]           o_ledg,
    output logic [N_FX-1:0]      o_ledr,
    output logic                 o_loop_wr,
    output logic                 o_loop_rd,
    output logic [LW-1:0]        o_loop_addr,
    output logic [LW-1:0]        o_loop_len
);

    localparam logic [PW-1:0] P_MAX = '1;

    state_t              state_q, state_n;
    logic [N_FX*PW-1:0]  params_q, params_n;
    logic [PW-1:0]       cur_val_n;
    logic [N_FX-1:0]     ledr_n;

    logic key_inc_q, key_dec_q, key_loop_q, key_mode_q;
    logic inc_edge, dec_edge, loop_edge, mode_edge;

    loop_mode_t lg_mode;
    logic       lg_start, lg_full, lg_empty;

    assign inc_edge  = i_key_inc  & ~key_inc_q;
    assign dec_edge  = i_key_dec  & ~key_dec_q;
    assign loop_edge = i_key_loop & ~key_loop_q;
    assign mode_edge = i_key_mode & ~key_mode_q;

    assign lg_mode  = (state_q == S_RECD)  ? LM_REC  :
                      (state_q == S_PLAYL) ? LM_PLAY : LM_IDLE;
    // Mode has priority in PLAY, so only a lone loop edge starts a recording.
    assign lg_start = (state_q == S_PLAY) && loop_edge && !mode_edge;

    always_comb begin
        state_n  = state_q;
        params_n = params_q;
        case (state_q)
            S_INIT: begin
                if (i_init_done) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (mode_edge)      state_n = S_SET;
                else if (loop_edge) state_n = S_RECD;
            end
            S_SET: begin
                if (mode_edge) state_n = S_PLAY;
                for (int k = 0; k < N_FX; k++) begin
                    if (i_sel == SW'(k) && (inc_edge ^ dec_edge)) begin
                        params_n[k*PW +: PW] = PW'(param_step(PSTEP_W'(params_q[k*PW +: PW]),
                                                              inc_edge, dec_edge, SAT,
                                                              PSTEP_W'(P_MAX)));
                    end
                end
            end
            S_RECD: begin
                // Stopping with nothing recorded falls straight back to PLAY.
                if (lg_full)        state_n = S_PLAYL;
                else if (loop_edge) state_n = (lg_empty && !i_sample_tick) ? S_PLAY : S_PLAYL;
            end
            S_PLAYL: begin
                if (loop_edge) state_n = S_PLAY;
            end
            default: state_n = S_INIT;
        endcase

        cur_val_n = '0;
        ledr_n    = (state_n == S_SET) ? '0 : i_fx_en;
        for (int k = 0; k < N_FX; k++) begin
            if (state_n == S_SET && i_sel == SW'(k)) begin
                cur_val_n = params_n[k*PW +: PW];
                ledr_n[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_INIT;
            params_q   <= P_DEFAULT;
            key_inc_q  <= 1'b0;
            key_dec_q  <= 1'b0;
            key_loop_q <= 1'b0;
            key_mode_q <= 1'b0;
            o_cur_val  <= '0;
            o_ledg     <= state_leds(S_INIT);
            o_ledr     <= '0;
        end else begin
            state_q    <= state_n;
            params_q   <= params_n;
            key_inc_q  <= i_key_inc;
            key_dec_q  <= i_key_dec;
            key_loop_q <= i_key_loop;
            key_mode_q <= i_key_mode;
            o_cur_val  <= cur_val_n;
            o_ledg     <= state_leds(state_n);
            o_ledr     <= ledr_n;
        end
    end

    assign o_state  = state_q;
    assign o_params = params_q;

    loop_addr_gen #(
        .LW(LW)
    ) u_loop (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .mode  (lg_mode),
        .start (lg_start),
        .stop  (loop_edge),
        .tick  (i_sample_tick),
        .addr  (o_loop_addr),
        .len   (o_loop_len),
        .wr    (o_loop_wr),
        .rd    (o_loop_rd),
        .full  (lg_full),
        .empty (lg_empty)
    );

endmodule

// File: tb/tb_fx_ctrl_sequencer.sv
// Two instances share stimulus: A = 8 effects, LW=20, wrapping parameters;
// B = 6 effects, LW=4, saturating parameters, nonzero defaults.
module tb_fx_ctrl_sequencer;

    localparam logic [17:0] PDEF_B = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       k_inc = 1'b0, k_dec = 1'b0, k_loop = 1'b0, k_mode = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] fx_en = 8'hA5;

    logic [2:0]  a_state, b_state;
    logic [23:0] a_params;
    logic [17:0] b_params;
    logic [2:0]  a_cur, b_cur;
    logic [8:0]  a_ledg, b_ledg;
    logic [7:0]  a_ledr;
    logic [5:0]  b_ledr;
    logic        a_wr, a_rd, b_wr, b_rd;
    logic [19:0] a_addr, a_len;
    logic [3:0]  b_addr, b_len;

    fx_ctrl_sequencer #(.N_FX(8), .PW(3), .LW(20), .SAT(1'b0), .P_DEFAULT(24'h0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
        .i_key_inc(k_inc), .i_key_dec(k_dec), .i_key_loop(k_loop), .i_key_mode(k_mode),
        .i_sel(sel), .i_fx_en(fx_en), .i_sample_tick(tick),
        .o_state(a_state), .o_params(a_params), .o_cur_val(a_cur), .o_ledg(a_ledg),
        .o_ledr(a_ledr), .o_loop_wr(a_wr), .o_loop_rd(a_rd), .o_loop_addr(a_addr),
        .o_loop_len(a_len));

    fx_ctrl_sequencer #(.N_FX(6), .PW(3), .LW(4), .SAT(1'b1), .P_DEFAULT(PDEF_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
        .i_key_inc(k_inc), .i_key_dec(k_dec), .i_key_loop(k_loop), .i_key_mode(k_mode),
        .i_sel(sel), .i_fx_en(fx_en[5:0]), .i_sample_tick(tick),
        .o_state(b_state), .o_params(b_params), .o_cur_val(b_cur), .o_ledg(b_ledg),
        .o_ledr(b_ledr), .o_loop_wr(b_wr), .o_loop_rd(b_rd), .o_loop_addr(b_addr),
        .o_loop_len(b_len));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int ma[8];
    int mb[6];
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ea(input bit wr, input bit rd, input int addr);
        return {42'd0, wr, rd, 20'(addr)};
    endfunction

    function automatic logic [63:0] eb(input bit wr, input bit rd, input int addr);
        return {58'd0, wr, rd, 4'(addr)};
    endfunction

    function automatic logic [23:0] pack_a();
        logic [23:0] r;
        for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(ma[k]);
        return r;
    endfunction

    function automatic logic [17:0] pack_b();
        logic [17:0] r;
        for (int k = 0; k < 6; k++) r[k*3 +: 3] = 3'(mb[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) ma[k] = 0;
        for (int k = 0; k < 6; k++) mb[k] = k;
    endtask

    // One clock; every strobe seen is popped from the scoreboard and compared.
    task automatic step();
        @(posedge clk);
        #1;
        if (a_wr || a_rd) begin
            if (qa.size() == 0) chk("a_strobe_unexpected", {42'd0, a_wr, a_rd, a_addr}, 64'd0);
            else                chk("a_strobe", {42'd0, a_wr, a_rd, a_addr}, qa.pop_front());
        end
        if (b_wr || b_rd) begin
            if (qb.size() == 0) chk("b_strobe_unexpected", {58'd0, b_wr, b_rd, b_addr}, 64'd0);
            else                chk("b_strobe", {58'd0, b_wr, b_rd, b_addr}, qb.pop_front());
        end
    endtask

    // keys = {mode, loop, dec, inc}: press for one cycle, then release one cycle
    task automatic press(input logic [3:0] keys);
        {k_mode, k_loop, k_dec, k_inc} = keys;
        step();
        {k_mode, k_loop, k_dec, k_inc} = 4'b0000;
        step();
    endtask

    task automatic do_tick(input bit ha, input logic [63:0] xa, input bit hb, input logic [63:0] xb);
        if (ha) qa.push_back(xa);
        if (hb) qb.push_back(xb);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_a_queue"}, 64'(qa.size()), 64'd0);
        chk({tag, "_b_queue"}, 64'(qb.size()), 64'd0);
    endtask

    initial begin
        model_reset();

        // reset and init
        repeat (3) step();
        chk("rst_a_state", a_state, 0);
        chk("rst_a_ledg", a_ledg, 9'h100);
        chk("rst_a_params", a_params, pack_a());
        chk("rst_b_params", b_params, pack_b());
        chk("rst_a_len", a_len, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_strobes", {a_wr, a_rd}, 0);
        rst = 1'b0;
        step();
        chk("init_wait_state", a_state, 0);
        init_done = 1'b1;
        step();
        chk("play_a_state", a_state, 1);
        chk("play_b_state", b_state, 1);
        chk("play_a_ledg", a_ledg, 9'h001);
        chk("play_a_params", a_params, pack_a());
        chk("play_a_ledr", a_ledr, 8'hA5);
        chk("play_b_ledr", b_ledr, 6'h25);
        chk("play_a_cur", a_cur, 0);

        // mode beats loop in the same cycle; loop is ignored in SET
        press(4'b1100);
        chk("set_a_state", a_state, 2);
        chk("set_a_ledg", a_ledg, 9'h002);
        press(4'b0100);
        chk("set_loop_ignored", a_state, 2);

        // held inc key acts once
        sel = 3'd2;
        k_inc = 1'b1;
        repeat (10) step();
        k_inc = 1'b0;
        step();
        ma[2] = (ma[2] + 1) % 8;
        if (mb[2] < 7) mb[2]++;
        chk("held_inc_a", a_params, pack_a());
        chk("held_inc_b", b_params, pack_b());
        chk("held_inc_a_cur", a_cur, 1);
        chk("held_inc_b_cur", b_cur, 3);
        chk("set_a_ledr", a_ledr, 8'h04);
        chk("set_b_ledr", b_ledr, 6'h04);

        // eight edges: wrap back on A, clamp at 7 on B
        repeat (8) begin
            press(4'b0001);
            ma[2] = (ma[2] + 1) % 8;
            if (mb[2] < 7) mb[2]++;
        end
        chk("wrap8_a", a_params, pack_a());
        chk("sat8_b", b_params, pack_b());
        chk("wrap8_a_cur", a_cur, 1);

        // dec at zero: A wraps to 7, B stays 0
        sel = 3'd0;
        press(4'b0010);
        ma[0] = (ma[0] + 7) % 8;
        if (mb[0] > 0) mb[0]--;
        chk("dec0_a", a_params, pack_a());
        chk("dec0_b", b_params, pack_b());
        chk("dec0_a_cur", a_cur, 7);
        chk("dec0_b_cur", b_cur, 0);

        // inc and dec together: no change
        sel = 3'd2;
        press(4'b0011);
        chk("incdec_a", a_params, pack_a());
        chk("incdec_b", b_params, pack_b());

        // sel 6 is out of range for B only
        sel = 3'd6;
        press(4'b0001);
        ma[6] = (ma[6] + 1) % 8;
        chk("sel6_a", a_params, pack_a());
        chk("sel6_b", b_params, pack_b());
        chk("sel6_b_cur", b_cur, 0);
        chk("sel6_b_ledr", b_ledr, 0);
        chk("sel6_a_ledr", a_ledr, 8'h40);
        chk("sel6_a_cur", a_cur, 1);

        // back to PLAY
        sel = 3'd2;
        press(4'b1000);
        chk("ret_a_state", a_state, 1);
        chk("ret_a_cur", a_cur, 0);
        chk("ret_a_ledr", a_ledr, 8'hA5);
        chk("ret_b_ledr", b_ledr, 6'h25);
        do_tick(0, 0, 0, 0);

        // record five samples
        press(4'b0100);
        chk("recd_a_state", a_state, 3);
        chk("recd_a_ledg", a_ledg, 9'h004);
        for (int i = 0; i < 5; i++) do_tick(1, ea(1, 0, i), 1, eb(1, 0, i));
        press(4'b1000);
        chk("recd_mode_ignored", a_state, 3);
        press(4'b0100);
        chk("playl_a_state", a_state, 4);
        chk("playl_a_ledg", a_ledg, 9'h008);
        chk("playl_a_len", a_len, 5);
        chk("playl_b_len", b_len, 5);
        chk_drained("rec5");

        // twelve reads wrapping at five
        for (int i = 0; i < 12; i++) do_tick(1, ea(0, 1, i % 5), 1, eb(0, 1, i % 5));
        chk_drained("play12");
        press(4'b1000);
        chk("playl_mode_ignored", a_state, 4);
        do_tick(1, ea(0, 1, 2), 1, eb(0, 1, 2));
        do_tick(1, ea(0, 1, 3), 1, eb(0, 1, 3));
        chk("pre_rst_a_addr", a_addr, 3);

        // asynchronous reset mid playback
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_a_state", a_state, 0);
        chk("arst_b_state", b_state, 0);
        chk("arst_a_addr", a_addr, 0);
        chk("arst_a_len", a_len, 0);
        chk("arst_b_len", b_len, 0);
        chk("arst_a_strobes", {a_wr, a_rd}, 0);
        chk("arst_a_params", a_params, pack_a());
        chk("arst_b_params", b_params, pack_b());
        chk("arst_a_ledg", a_ledg, 9'h100);
        step();
        rst = 1'b0;
        step();
        chk("rearm_a_state", a_state, 1);

        // B fills at 16 writes, A keeps recording
        press(4'b0100);
        for (int i = 0; i < 16; i++) do_tick(1, ea(1, 0, i), 1, eb(1, 0, i));
        chk("full_b_state", b_state, 4);
        chk("full_b_len", b_len, 15);
        chk("full_b_ledg", b_ledg, 9'h008);
        chk("full_a_state", a_state, 3);
        do_tick(1, ea(1, 0, 16), 1, eb(0, 1, 0));
        chk_drained("full");
        press(4'b0100);
        chk("stop17_a_state", a_state, 4);
        chk("stop17_a_len", a_len, 17);
        chk("leave_b_state", b_state, 1);
        chk("leave_b_len", b_len, 15);
        press(4'b0100);
        chk("a_back_play", a_state, 1);
        chk("b_rec_again", b_state, 3);

        // B stops with nothing recorded
        press(4'b0100);
        chk("empty_b_state", b_state, 1);
        chk("empty_b_len", b_len, 0);
        chk("empty_a_state", a_state, 3);

        // tick and loop edge together on A: the write counts
        qa.push_back(ea(1, 0, 0));
        tick = 1'b1;
        k_loop = 1'b1;
        step();
        tick = 1'b0;
        k_loop = 1'b0;
        step();
        chk("same_a_state", a_state, 4);
        chk("same_a_len", a_len, 1);
        chk("same_b_state", b_state, 3);
        do_tick(1, ea(0, 1, 0), 1, eb(1, 0, 0));
        do_tick(1, ea(0, 1, 0), 1, eb(1, 0, 1));
        chk_drained("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
